exec_ctrl: RTL
==============

# exec_ctrl

Single-issue execute controller sitting directly upstream of the ALU. Accepts one 32-bit instruction at a time over a valid/ready handshake, reads operands from an internal 32×32 register file, drives the ALU's level enable/ready handshake, and writes the ALU result back to the destination register. An unanswered ALU request, such as an undefined function code, is caught by a timeout and latched as a sticky fault.

## Interface
- TIMEOUT, 16: EXEC cycles without `alu_rdy` before fault; ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction: func[31:26], rd[25:21], rs[20:16], rt = instr[15:11], imm[15:0].
- instr_valid  in  1  instr valid.
- instr_ready  out  1  controller can accept an instruction.
- alu_en  out  1  ALU enable (level).
- alu_func  out  6  to ALU func.
- alu_x1  out  32  to ALU x1 (reg[rs]).
- alu_x2  out  32  to ALU x2 (reg[rt]).
- alu_imm  out  16  to ALU imm.
- alu_y  in  32  ALU result.
- alu_rdy  in  1  ALU ready.
- wb_valid  out  1  one-cycle pulse: write-back this cycle.
- wb_addr  out  5  write-back register index.
- wb_data  out  32  write-back value.
- busy  out  1  state ≠ IDLE.
- fault  out  1  sticky timeout flag.
- dbg_addr  in  5  debug read index.
- dbg_data  out  32  reg[dbg_addr], combinational.

## Operation
- States: IDLE, READ, EXEC, WB, DRAIN, FAULT.
- IDLE: `instr_ready` = 1. On `instr_valid`, latch instr → READ.
- READ: register reg[rs] and reg[rt] into operand regs; latch func and imm → EXEC.
- EXEC: `alu_en` = 1 and the timeout counter increments.
  - `alu_rdy` sampled 1 → capture `alu_y` into result reg, go to WB.
  - Otherwise, counter == TIMEOUT−1 → FAULT.
- WB: `alu_en` = 0, `wb_valid` = 1. If rd ≠ 0, write reg[rd] ← result → DRAIN.
- DRAIN: `alu_en` = 0. Wait for `alu_rdy` = 0, then → IDLE. This guarantees a clean rising edge of enable on the next issue.
- FAULT: `alu_en` = 0, `instr_ready` = 0, `fault` = 1. Held until `rst`.
- r0 reads as 0 and is never written; a `wb_valid` pulse with rd = 0 still occurs.
- Func codes are passed through unchanged; the controller does not decode them.
- The `MV` op uses imm; x1/x2 are still driven from rs/rt (don't-care to the ALU).
- All arithmetic is done by the ALU. Only the timeout counter lives here, width clog2(TIMEOUT); it resets to 0 on entry to EXEC.

## Timing
- All outputs are registered or decoded from state. `dbg_data` is the only combinational read.
- Reset values:
  - state IDLE, `instr_ready` 1, `alu_en` 0, `wb_valid` 0, `busy` 0, `fault` 0.
  - `alu_func`/`alu_x1`/`alu_x2`/`alu_imm`/`wb_addr`/`wb_data` 0; all 32 registers 0.
- Nominal sequence (accept at cycle 0):
  - READ c1, EXEC c2 (`alu_en` high), WB c3 (`wb_valid` high), DRAIN c4, IDLE c5.
  - Accept-to-accept = 5 cycles minimum.
  - Written value is visible on `dbg_data` from c4.
- `alu_func`/`alu_x1`/`alu_x2`/`alu_imm` are stable from READ exit until DRAIN exit, i.e. before and throughout `alu_en`.
- `instr_valid` while not in IDLE: ignored, no accept.
- `alu_rdy` high on entry to EXEC (stale): not sampled as completion until `alu_en` has been high one cycle. DRAIN normally prevents this case.
- Fault timing: `alu_rdy` never rises → FAULT entered after exactly TIMEOUT cycles of `alu_en`. No register write and no `wb_valid`.
- `rst` mid-operation: next cycle is IDLE and `alu_en` = 0. The in-flight result is discarded and registers are cleared.

## Structure
- Func codes (ADD, SUB, SHR, SHL, AND, OR, XOR, MV) and the instruction field bit positions come from the shared definitions.hv header. Add field-offset macros there rather than hard-coding slices.
- One natural sub-module, `regfile`: 32×32, two synchronous read ports, one write port, r0 forced to 0, async debug read, synchronous reset clear.

## Test plan
- Reset, then MV r1 ← imm 0x0005, then MV r2 ← imm 0x0003, both against the ALU → `dbg_data`(r1) = 5 and `dbg_data`(r2) = 3; each `wb_valid` pulse is 1 cycle at c3 after accept.
- Then ADD r3 = r1 + r2 → `wb_addr` = 3, `wb_data` = 8. SUB r4 = r2 − r1 → `wb_data` = 0xFFFFFFFE. Accept-to-accept = 5 cycles.
- MV r0 ← imm 0x1234 → `wb_valid` pulses, `dbg_data`(r0) stays 0.
- Undefined func code, TIMEOUT = 16 → `alu_en` high for exactly 16 cycles, then `fault` = 1, `instr_ready` = 0, no write. Held until `rst`, then `fault` = 0.
- `instr_valid` held high across back-to-back instructions → exactly one accept per IDLE visit; no instruction is dropped or duplicated.
- `rst` asserted during EXEC → next cycle `alu_en` = 0, `busy` = 0, all registers read 0, no `wb_valid`.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execute controller: instruction field layout,
// ALU function codes, FSM state encoding and an instruction field decoder.
package exec_ctrl_pkg;

  localparam int unsigned TIMEOUT_DEF = 16;

  localparam int FUNC_HI = 31;
  localparam int FUNC_LO = 26;
  localparam int RD_HI   = 25;
  localparam int RD_LO   = 21;
  localparam int RS_HI   = 20;
  localparam int RS_LO   = 16;
  localparam int RT_HI   = 15;
  localparam int RT_LO   = 11;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_SHR = 6'd2;
  localparam logic [5:0] FN_SHL = 6'd3;
  localparam logic [5:0] FN_AND = 6'd4;
  localparam logic [5:0] FN_OR  = 6'd5;
  localparam logic [5:0] FN_XOR = 6'd6;
  localparam logic [5:0] FN_MV  = 6'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_DRAIN,
    ST_FAULT
  } state_e;

  // rt and imm overlap in the encoding; both views are kept.
  typedef struct packed {
    logic [5:0]  func;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } instr_t;

  function automatic instr_t decode_instr(input logic [31:0] raw);
    instr_t d;
    d.func = raw[FUNC_HI:FUNC_LO];
    d.rd   = raw[RD_HI:RD_LO];
    d.rs   = raw[RS_HI:RS_LO];
    d.rt   = raw[RT_HI:RT_LO];
    d.imm  = raw[IMM_HI:IMM_LO];
    return d;
  endfunction

endpackage

// File: rtl/exec_ctrl_regfile.sv
// 32x32 register file: two enabled synchronous read ports, one write port,
// r0 hard-wired to zero, combinational debug read, synchronous clear.
module exec_ctrl_regfile
  import exec_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [31:0] mem [32];

  // NOTE: the whole array is cleared on reset because the controller must
  // present all-zero registers after rst; this keeps it out of block RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      if (we && (wr_addr != 5'd0)) mem[wr_addr] <= wr_data;
      if (rd_en) begin
        rd_data_a <= (rd_addr_a == 5'd0) ? 32'd0 : mem[rd_addr_a];
        rd_data_b <= (rd_addr_b == 5'd0) ? 32'd0 : mem[rd_addr_b];
      end
    end
  end

  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : mem[dbg_addr];

endmodule

// File: rtl/exec_ctrl.sv
// Single-issue execute controller: fetches operands, drives the ALU
// enable/ready handshake, writes the result back, and traps ALU timeouts.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        alu_en,
  output logic [5:0]  alu_func,
  output logic [31:0] alu_x1,
  output logic [31:0] alu_x2,
  output logic [15:0] alu_imm,
  input  logic [31:0] alu_y,
  input  logic        alu_rdy,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        fault,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state;
  instr_t        ir;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ir       <= '0;
      cnt      <= '0;
      alu_func <= '0;
      alu_imm  <= '0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            ir    <= decode_instr(instr);
            state <= ST_READ;
          end
        end
        ST_READ: begin
          alu_func <= ir.func;
          alu_imm  <= ir.imm;
          cnt      <= '0;
          state    <= ST_EXEC;
        end
        ST_EXEC: begin
          if (alu_rdy) begin
            wb_data <= alu_y;
            wb_addr <= ir.rd;
            state   <= ST_WB;
          end else if (cnt == CNT_LAST) begin
            state <= ST_FAULT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WB:    state <= ST_DRAIN;
        // Waiting for ready to fall guarantees a fresh enable edge next issue.
        ST_DRAIN: if (!alu_rdy) state <= ST_IDLE;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (state == ST_IDLE);
  assign alu_en      = (state == ST_EXEC);
  assign wb_valid    = (state == ST_WB);
  assign busy        = (state != ST_IDLE);
  assign fault       = (state == ST_FAULT);

  exec_ctrl_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (state == ST_READ),
    .rd_addr_a (ir.rs),
    .rd_addr_b (ir.rt),
    .rd_data_a (alu_x1),
    .rd_data_b (alu_x2),
    .we        (state == ST_WB),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

endmodule
